riscv_mem_arbiter: RTL and testbench

- Sits directly downstream of the 5-stage RISC-V core.
- Merges the core's instruction-memory and data-memory request/response port pairs onto a single shared memory port.
- Arbitrates requests round-robin and records the issuing port of every accepted request in an in-order tag FIFO.
- Routes each in-order memory response back to the port that issued it.

---
 rtl/riscv_mem_arbiter_pkg.sv | 22 ++
 rtl/riscv_mem_arbiter_tagq.sv | 56 +++++
 rtl/riscv_mem_arbiter.sv | 91 +++++++++
 tb/tb_riscv_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: issuing-port
// tags and helpers that size the memory request/response messages.
package riscv_mem_arbiter_pkg;

  // Tag recorded per accepted request; selects the response destination.
  localparam logic ARB_TAG_IMEM = 1'b0;
  localparam logic ARB_TAG_DMEM = 1'b1;

  // Control bits carried in every memory message (type + len).
  localparam int MEM_MSG_CTRL_SZ = 3;

  // Request message: {type, addr, len, data}.
  function automatic int memreq_msg_sz(input int addr_sz, input int data_sz);
    return MEM_MSG_CTRL_SZ + addr_sz + data_sz;
  endfunction

  // Response message: {type, len, data}.
  function automatic int memresp_msg_sz(input int data_sz);
    return MEM_MSG_CTRL_SZ + data_sz;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_tagq.sv
// In-order tag FIFO: one bit per outstanding request naming the port that
// issued it. Enqueue on full and dequeue on empty are ignored.
module riscv_mem_arbiter_tagq
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq,
  input  logic                       enq_tag,
  input  logic                       deq,
  output logic                       head_tag,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_enq;
  logic             do_deq;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_enq   = enq & ~full;
  assign do_deq   = deq & ~empty;
  assign head_tag = mem[rd_ptr];

  // Tag storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_tag;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Merges the core's imem and dmem ports onto one memory port. Requests are
// granted round-robin and passed through combinationally; the issuing port of
// each accepted request is queued so in-order responses can be steered back.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_SZ = 32,
  parameter int DATA_SZ = 32,
  parameter int DEPTH   = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [memreq_msg_sz(ADDR_SZ,DATA_SZ)-1:0] imemreq_msg,
  input  logic                                    imemreq_val,
  output logic                                    imemreq_rdy,
  output logic [memresp_msg_sz(DATA_SZ)-1:0]      imemresp_msg,
  output logic                                    imemresp_val,
  input  logic [memreq_msg_sz(ADDR_SZ,DATA_SZ)-1:0] dmemreq_msg,
  input  logic                                    dmemreq_val,
  output logic                                    dmemreq_rdy,
  output logic [memresp_msg_sz(DATA_SZ)-1:0]      dmemresp_msg,
  output logic                                    dmemresp_val,
  output logic [memreq_msg_sz(ADDR_SZ,DATA_SZ)-1:0] memreq_msg,
  output logic                                    memreq_val,
  input  logic                                    memreq_rdy,
  input  logic [memresp_msg_sz(DATA_SZ)-1:0]      memresp_msg,
  input  logic                                    memresp_val,
  output logic [$clog2(DEPTH):0]                  outstanding,
  output logic                                    resp_err
);

  logic q_full;
  logic q_empty;
  logic head_tag;
  logic space;
  logic grant_dmem;
  logic grant_imem;
  logic fire;
  logic pop;
  logic rr_dmem;   // 1: dmem favoured when both ports request

  // Space comes from registered fill level only, so a same-cycle pop never
  // opens a slot for a same-cycle push.
  assign space = ~q_full;

  // Round-robin grant; a lone requester always wins.
  always_comb begin
    grant_dmem = dmemreq_val & (~imemreq_val | rr_dmem);
    grant_imem = imemreq_val & ~grant_dmem;
  end

  assign memreq_val  = (imemreq_val | dmemreq_val) & space;
  assign memreq_msg  = grant_dmem ? dmemreq_msg : imemreq_msg;
  assign imemreq_rdy = grant_imem & memreq_rdy & space;
  assign dmemreq_rdy = grant_dmem & memreq_rdy & space;
  assign fire        = memreq_val & memreq_rdy;

  // Responses are consumed the cycle they arrive; empty-queue responses drop.
  assign pop          = memresp_val & ~q_empty;
  assign imemresp_val = pop & (head_tag == ARB_TAG_IMEM);
  assign dmemresp_val = pop & (head_tag == ARB_TAG_DMEM);
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;

  riscv_mem_arbiter_tagq #(
    .DEPTH (DEPTH)
  ) u_tagq (
    .clk      (clk),
    .reset    (reset),
    .enq      (fire),
    .enq_tag  (grant_dmem ? ARB_TAG_DMEM : ARB_TAG_IMEM),
    .deq      (pop),
    .head_tag (head_tag),
    .full     (q_full),
    .empty    (q_empty),
    .count    (outstanding)
  );

  // Pointer moves away from the favoured port once that port is served;
  // resp_err latches any response that had no matching request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_dmem  <= 1'b1;
      resp_err <= 1'b0;
    end else begin
      if (fire && (grant_dmem == rr_dmem)) rr_dmem <= ~rr_dmem;
      if (memresp_val && q_empty) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

  localparam int ADDR_SZ = 32;
  localparam int DATA_SZ = 32;
  localparam int DEPTH   = 4;
  localparam int REQ_W   = 3 + ADDR_SZ + DATA_SZ;
  localparam int RESP_W  = 3 + DATA_SZ;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [REQ_W-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
  logic              imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  logic [RESP_W-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
  logic              imemresp_val, dmemresp_val;
  logic              memreq_val, memreq_rdy, memresp_val;
  logic [CNT_W-1:0]  outstanding;
  logic              resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: queue of issuing ports (1 = dmem), who is favoured
  // on contention, and the sticky error flag.
  bit q[$];
  bit fav_dmem;
  bit m_err;

  // Model predictions for the current inputs.
  int winner;          // -1 none, 0 imem, 1 dmem
  bit e_mval, e_irdy, e_drdy, e_fire, e_ir, e_dr;
  logic [REQ_W-1:0] e_msg;

  riscv_mem_arbiter #(.ADDR_SZ(ADDR_SZ), .DATA_SZ(DATA_SZ), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] req(input logic [ADDR_SZ-1:0] a,
                                           input logic [DATA_SZ-1:0] d);
    return {1'b0, a, 2'd0, d};
  endfunction

  function automatic logic [RESP_W-1:0] rsp(input logic [DATA_SZ-1:0] d);
    return {1'b0, 2'd0, d};
  endfunction

  task automatic model_reset();
    q.delete();
    fav_dmem = 1'b1;
    m_err    = 1'b0;
  endtask

  task automatic model_eval();
    bit has_space;
    has_space = (q.size() < DEPTH);
    if (imemreq_val && dmemreq_val) winner = fav_dmem ? 1 : 0;
    else if (dmemreq_val)           winner = 1;
    else if (imemreq_val)           winner = 0;
    else                            winner = -1;
    e_mval = (winner != -1) && has_space;
    e_msg  = (winner == 1) ? dmemreq_msg : imemreq_msg;
    e_irdy = (winner == 0) && memreq_rdy && has_space;
    e_drdy = (winner == 1) && memreq_rdy && has_space;
    e_fire = e_mval && memreq_rdy;
    e_ir = 1'b0;
    e_dr = 1'b0;
    if (memresp_val && q.size() > 0) begin
      e_ir = (q[0] == 1'b0);
      e_dr = (q[0] == 1'b1);
    end
  endtask

  // Advance model and DUT by one clock; returns at posedge + 2.
  task automatic tick();
    model_eval();
    if (memresp_val) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err = 1'b1;
    end
    if (e_fire) begin
      q.push_back(winner == 1);
      if ((winner == 1) == fav_dmem) fav_dmem = ~fav_dmem;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    imemreq_val = 0; dmemreq_val = 0; memreq_rdy = 0; memresp_val = 0;
    imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    n_checks++;
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    n_checks++;
    if ({memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_val_rdy got=%b exp=00000",
               {memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val});
    end
  endtask

  task automatic test_single();
    apply_reset();
    imemreq_val = 1; imemreq_msg = req(32'h0000_1000, 32'h0); memreq_rdy = 1;
    #1;
    n_checks++;
    if (memreq_msg !== imemreq_msg || memreq_val !== 1'b1) begin
      n_fail++; $display("FAIL single_req got=%h/%b exp=%h/1", memreq_msg, memreq_val, imemreq_msg);
    end
    n_checks++;
    if (imemreq_rdy !== 1'b1 || dmemreq_rdy !== 1'b0) begin
      n_fail++; $display("FAIL single_rdy got=%b%b exp=10", imemreq_rdy, dmemreq_rdy);
    end
    tick();
    imemreq_val = 0; memresp_val = 1; memresp_msg = rsp(32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (imemresp_val !== 1'b1 || imemresp_msg[DATA_SZ-1:0] !== 32'hDEAD_BEEF || dmemresp_val !== 1'b0) begin
      n_fail++; $display("FAIL single_resp got=%b/%h/%b exp=1/deadbeef/0",
                         imemresp_val, imemresp_msg[DATA_SZ-1:0], dmemresp_val);
    end
    tick();
    memresp_val = 0;
    #1;
    n_checks++;
    if (outstanding !== '0) begin n_fail++; $display("FAIL single_drain got=%0d exp=0", outstanding); end
  endtask

  task automatic test_contention();
    bit exp_order [4];
    exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;
    apply_reset();
    memreq_rdy = 1; imemreq_val = 1; dmemreq_val = 1;
    for (int i = 0; i < 4; i++) begin
      imemreq_msg = req(32'h100 + i, 32'hA000 + i);
      dmemreq_msg = req(32'h200 + i, 32'hB000 + i);
      #1;
      n_checks++;
      if (memreq_msg !== (exp_order[i] ? dmemreq_msg : imemreq_msg)) begin
        n_fail++; $display("FAIL contention_grant%0d got=%h exp_port=%0d", i, memreq_msg, exp_order[i]);
      end
      tick();
    end
    imemreq_val = 0; dmemreq_val = 0; memresp_val = 1;
    for (int i = 0; i < 4; i++) begin
      memresp_msg = rsp(32'hC000 + i);
      #1;
      n_checks++;
      if (dmemresp_val !== exp_order[i] || imemresp_val !== !exp_order[i] ||
          memresp_msg !== (exp_order[i] ? dmemresp_msg : imemresp_msg)) begin
        n_fail++; $display("FAIL contention_route%0d got=i%b/d%b exp_port=%0d",
                           i, imemresp_val, dmemresp_val, exp_order[i]);
      end
      tick();
    end
    memresp_val = 0;
  endtask

  task automatic test_full();
    apply_reset();
    memreq_rdy = 1; imemreq_val = 1;
    for (int i = 0; i < DEPTH; i++) begin
      imemreq_msg = req(32'h300 + i, 0);
      tick();
    end
    #1;
    n_checks++;
    if (outstanding !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL full_count got=%0d exp=%0d", outstanding, DEPTH); end
    n_checks++;
    if ({memreq_val, imemreq_rdy, dmemreq_rdy} !== 3'b000) begin
      n_fail++; $display("FAIL full_block got=%b exp=000", {memreq_val, imemreq_rdy, dmemreq_rdy});
    end
    memresp_val = 1; memresp_msg = rsp(32'h5);
    #1;
    n_checks++;
    if (memreq_val !== 1'b0 || imemreq_rdy !== 1'b0 || imemresp_val !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_same_cycle got=%b%b%b exp=001", memreq_val, imemreq_rdy, imemresp_val);
    end
    tick();
    memresp_val = 0;
    #1;
    n_checks++;
    if (memreq_val !== 1'b1 || imemreq_rdy !== 1'b1 || outstanding !== CNT_W'(DEPTH - 1)) begin
      n_fail++; $display("FAIL full_next_cycle got=%b%b/%0d exp=11/%0d", memreq_val, imemreq_rdy, outstanding, DEPTH - 1);
    end
    tick();
    imemreq_val = 0;
    #1;
    n_checks++;
    if (outstanding !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL full_refill got=%0d exp=%0d", outstanding, DEPTH); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    memreq_rdy = 1;
    dmemreq_val = 1; dmemreq_msg = req(32'h40, 1); tick();
    dmemreq_val = 0; imemreq_val = 1; imemreq_msg = req(32'h44, 2); tick();
    imemreq_msg = req(32'h48, 3); memresp_val = 1; memresp_msg = rsp(32'h77);
    #1;
    n_checks++;
    if (dmemresp_val !== 1'b1 || imemresp_val !== 1'b0 || imemreq_rdy !== 1'b1) begin
      n_fail++; $display("FAIL pushpop_route got=d%b i%b rdy%b exp=d1 i0 rdy1", dmemresp_val, imemresp_val, imemreq_rdy);
    end
    tick();
    imemreq_val = 0; memresp_val = 0;
    #1;
    n_checks++;
    if (outstanding !== CNT_W'(2)) begin n_fail++; $display("FAIL pushpop_count got=%0d exp=2", outstanding); end
  endtask

  task automatic test_spurious();
    apply_reset();
    memresp_val = 1; memresp_msg = rsp(32'h99);
    #1;
    n_checks++;
    if (imemresp_val !== 1'b0 || dmemresp_val !== 1'b0) begin
      n_fail++; $display("FAIL spurious_drop got=%b%b exp=00", imemresp_val, dmemresp_val);
    end
    tick();
    memresp_val = 0;
    tick(); tick();
    n_checks++;
    if (resp_err !== 1'b1) begin n_fail++; $display("FAIL spurious_sticky got=%b exp=1", resp_err); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    memreq_rdy = 1; dmemreq_val = 1;
    for (int i = 0; i < 3; i++) begin dmemreq_msg = req(32'h500 + i, 0); tick(); end
    dmemreq_val = 0;
    #1;
    n_checks++;
    if (outstanding !== CNT_W'(3)) begin n_fail++; $display("FAIL midflight_pre got=%0d exp=3", outstanding); end
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (outstanding !== '0) begin n_fail++; $display("FAIL midflight_async got=%0d exp=0", outstanding); end
    @(posedge clk); #2;
    reset = 1'b1;
    memresp_val = 1; memresp_msg = rsp(32'h1);
    tick();
    memresp_val = 0;
    #1;
    n_checks++;
    if (resp_err !== 1'b1) begin n_fail++; $display("FAIL midflight_err got=%b exp=1", resp_err); end
  endtask

  task automatic test_random();
    logic [95:0] r;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      imemreq_val = ($urandom_range(0, 99) < 60);
      dmemreq_val = ($urandom_range(0, 99) < 60);
      memreq_rdy  = ($urandom_range(0, 99) < 75);
      memresp_val = (q.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 3);
      r = {$urandom, $urandom, $urandom}; imemreq_msg = r[REQ_W-1:0];
      r = {$urandom, $urandom, $urandom}; dmemreq_msg = r[REQ_W-1:0];
      r = {$urandom, $urandom, $urandom}; memresp_msg = r[RESP_W-1:0];
      #1;
      model_eval();
      n_checks++;
      if (memreq_val !== e_mval || imemreq_rdy !== e_irdy || dmemreq_rdy !== e_drdy) begin
        n_fail++; $display("FAIL rand_req c=%0d got=%b%b%b exp=%b%b%b", c,
                           memreq_val, imemreq_rdy, dmemreq_rdy, e_mval, e_irdy, e_drdy);
      end
      if (e_mval) begin
        n_checks++;
        if (memreq_msg !== e_msg) begin n_fail++; $display("FAIL rand_msg c=%0d got=%h exp=%h", c, memreq_msg, e_msg); end
      end
      n_checks++;
      if (imemresp_val !== e_ir || dmemresp_val !== e_dr ||
          (e_ir && imemresp_msg !== memresp_msg) || (e_dr && dmemresp_msg !== memresp_msg)) begin
        n_fail++; $display("FAIL rand_resp c=%0d got=i%b d%b exp=i%b d%b", c, imemresp_val, dmemresp_val, e_ir, e_dr);
      end
      n_checks++;
      if (outstanding !== CNT_W'(q.size()) || resp_err !== m_err) begin
        n_fail++; $display("FAIL rand_state c=%0d got=%0d/%b exp=%0d/%b", c, outstanding, resp_err, q.size(), m_err);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #3;
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_push_pop();
    test_spurious();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
